det_share_ctrl: RTL and testbench

Time-multiplexing controller that shares one a/b pattern-detector datapath (S0→S1→S2 sequence recogniser) among N_CH requesters. Each channel keeps its own 2-bit detector state; a round-robin arbiter grants one pending sample per cycle and advances only that channel's state. A registered hit/channel report and a saturating hit counter go to the downstream logic. It sits between the per-channel input samplers and the event/display logic.

---
 rtl/det_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/det_share_ctrl.sv | 78 +++++++
 tb/tb_det_share_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/det_pkg.sv
// rtl/det_pkg.sv - shared state encodings and transition function for the a/b detector
package det_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } det_state_t;

  // One step of the S0->S1->S2 recogniser; the unused 2'b11 code recovers to S0.
  function automatic det_state_t det_next(input det_state_t s, input logic a, input logic b);
    case (s)
      S0:      return a ? S1 : S0;
      S1:      return b ? S2 : S0;
      S2:      return (a && b) ? S2 : S0;
      default: return S0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with last-granted pointer
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_vld
);

  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] cand;

  // Search from the channel after the last winner, wrapping; no grant while in reset.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = W'((32'(ptr_q) + k) % N);
      if (reset && !grant_vld && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_vld   = 1'b1;
      end
    end
    ptr_d = grant_vld ? grant_idx : ptr_q;
  end

  // Pointer register; resets to the last index so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (!reset) ptr_q <= W'(N - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/det_share_ctrl.sv
// rtl/det_share_ctrl.sv - time-multiplexed a/b pattern detector shared by N_CH channels
module det_share_ctrl
  import det_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH-1:0]   a,
  input  logic [N_CH-1:0]   b,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   grant,
  output logic              hit,
  output logic [CH_W-1:0]   hit_ch,
  output logic [2*N_CH-1:0] state_o,
  output logic [7:0]        hit_cnt
);

  det_state_t      st_q [N_CH];
  det_state_t      st_d [N_CH];
  det_state_t      sel_nxt;
  logic [CH_W-1:0] gidx;
  logic            gvld;
  logic            hit_q, hit_d;
  logic [CH_W-1:0] hit_ch_q, hit_ch_d;
  logic [7:0]      hit_cnt_q, hit_cnt_d;

  // Cleared channels are withheld from arbitration so their sample stays pending.
  rr_arbiter #(.N(N_CH)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req & ~clr),
    .grant     (grant),
    .grant_idx (gidx),
    .grant_vld (gvld)
  );

  // Shared datapath: mux the granted channel into det_next, update only that channel.
  always_comb begin
    sel_nxt = det_next(st_q[gidx], a[gidx], b[gidx]);
    for (int i = 0; i < N_CH; i++) begin
      st_d[i] = st_q[i];
      if (gvld && (gidx == CH_W'(i))) st_d[i] = sel_nxt;
      if (clr[i])                     st_d[i] = S0;
    end
    hit_d     = gvld && (sel_nxt == S2);
    hit_ch_d  = gvld ? gidx : hit_ch_q;
    hit_cnt_d = (hit_d && (hit_cnt_q != 8'hFF)) ? hit_cnt_q + 8'd1 : hit_cnt_q;
  end

  // Per-channel state plus registered hit report and saturating counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) st_q[i] <= S0;
      hit_q     <= 1'b0;
      hit_ch_q  <= '0;
      hit_cnt_q <= 8'd0;
    end else begin
      for (int i = 0; i < N_CH; i++) st_q[i] <= st_d[i];
      hit_q     <= hit_d;
      hit_ch_q  <= hit_ch_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  // Flatten channel states for the downstream report bus.
  always_comb begin
    state_o = '0;
    for (int i = 0; i < N_CH; i++) state_o[2*i +: 2] = st_q[i];
  end

  assign hit     = hit_q;
  assign hit_ch  = hit_ch_q;
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_det_share_ctrl.sv
// tb/tb_det_share_ctrl.sv - directed scoreboard bench for det_share_ctrl
module tb_det_share_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, a, b, clr;
  logic [3:0] grant;
  logic       hit;
  logic [1:0] hit_ch;
  logic [7:0] state_o;
  logic [7:0] hit_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       hit;
    logic [1:0] ch;
    logic [7:0] cnt;
    logic [7:0] st;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] m_st [4];
  logic [1:0] m_hit_ch;
  logic [7:0] m_cnt;

  det_share_ctrl #(.N_CH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .a       (a),
    .b       (b),
    .clr     (clr),
    .grant   (grant),
    .hit     (hit),
    .hit_ch  (hit_ch),
    .state_o (state_o),
    .hit_cnt (hit_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_next(input logic [1:0] s, input logic av, input logic bv);
    if (s == 2'b00 && av)        return 2'b01;
    if (s == 2'b01 && bv)        return 2'b10;
    if (s == 2'b10 && av && bv)  return 2'b10;
    return 2'b00;
  endfunction

  // Drive one cycle, check the combinational grant, predict and check the post-edge outputs.
  task automatic step(input logic rst, input logic [3:0] rq, input logic [3:0] av,
                      input logic [3:0] bv, input logic [3:0] cl, input logic [3:0] exp_g,
                      input string tag);
    exp_t e;
    logic m_hit;
    reset = rst; req = rq; a = av; b = bv; clr = cl;
    #1;
    chk({tag, " grant"}, 32'(grant), 32'(exp_g));
    m_hit = 1'b0;
    if (!rst) begin
      for (int i = 0; i < 4; i++) m_st[i] = 2'b00;
      m_hit_ch = 2'd0;
      m_cnt    = 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (exp_g[i]) begin
          m_st[i]  = ref_next(m_st[i], av[i], bv[i]);
          m_hit    = (m_st[i] == 2'b10);
          m_hit_ch = 2'(i);
        end
        if (cl[i]) m_st[i] = 2'b00;
      end
      if (m_hit && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    e.hit = m_hit;
    e.ch  = m_hit_ch;
    e.cnt = m_cnt;
    e.st  = {m_st[3], m_st[2], m_st[1], m_st[0]};
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, " hit"},     32'(hit),     32'(e.hit));
    chk({e.tag, " hit_ch"},  32'(hit_ch),  32'(e.ch));
    chk({e.tag, " hit_cnt"}, 32'(hit_cnt), 32'(e.cnt));
    chk({e.tag, " state_o"}, 32'(state_o), 32'(e.st));
  endtask

  initial begin
    reset = 1'b0; req = '0; a = '0; b = '0; clr = '0;
    for (int i = 0; i < 4; i++) m_st[i] = 2'b00;
    m_hit_ch = 2'd0;
    m_cnt    = 8'd0;
    @(posedge clk);
    #1;

    // Reset held two cycles with everyone requesting: no grant leaks out
    step(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "rst0");
    step(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "rst1");
    chk("rst state_o", 32'(state_o), 32'h0);
    chk("rst hit_cnt", 32'(hit_cnt), 32'h0);

    // Fairness: channel 0 first after reset, then strict rotation
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, "fair0");
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0010, "fair1");
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0100, "fair2");
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1000, "fair3");
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, "fair4");
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0010, "fair5");
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0100, "fair6");
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1000, "fair7");

    // Single channel detect on ch2: (1,0) (0,1) (1,1)
    step(1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, "ch2_s1");
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100, "ch2_s2");
    step(1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, "ch2_hold");
    chk("ch2 hit_cnt", 32'(hit_cnt), 32'd2);

    // Isolation: ch0 sees a only, ch1 sees b only; no cross-talk
    step(1'b1, 4'b0011, 4'b0001, 4'b0010, 4'b0000, 4'b0001, "iso_ch0");
    step(1'b1, 4'b0011, 4'b0001, 4'b0010, 4'b0000, 4'b0010, "iso_ch1");

    // Clear priority: ch3 in S1, then clr[3] with req[3] held
    step(1'b1, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, "ch3_s1");
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 4'b0001, "clr_g0");
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 4'b0010, "clr_g1");
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 4'b0100, "clr_g2");
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 4'b0001, "clr_wrap");

    // Saturation: ch0 reaches S2 and stays there, one hit per cycle
    for (int n = 0; n < 262; n++)
      step(1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, "sat");
    chk("sat hit_cnt", 32'(hit_cnt), 32'hFF);

    // Reset mid-sequence discards state and the counter
    step(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "rst_mid");
    chk("post rst hit_cnt", 32'(hit_cnt), 32'h0);
    step(1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, "post_rst_g");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
